// File: rtl/pmod_serial_pkg.sv
// Shared definitions for the PMOD bit-serial link (transmitter and receiver).
// Holds default frame geometry and the transmitter state encoding.
package pmod_serial_pkg;

    localparam int WORD_W_DEF       = 9;
    localparam int CLKS_PER_BIT_DEF = 2;
    localparam int GAP_BITS_DEF     = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/pmod_bit_timer.sv
// Bit-period phase counter for the PMOD serial transmitter.
// tick marks the last clock of a bit period; half_nxt is the clock-pin level for the coming cycle.
module pmod_bit_timer #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic half_nxt
);

    localparam int PH_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLKS_PER_BIT / 2);

    logic [PH_W-1:0] phase_r;
    logic [PH_W-1:0] phase_nxt_s;

    // Next phase: restart on accept, wrap at end of bit period, park at zero when idle
    always_comb begin
        phase_nxt_s = phase_r;
        tick        = 1'b0;
        if (clr) begin
            phase_nxt_s = {PH_W{1'b0}};
        end else if (en) begin
            if (phase_r == PH_LAST) begin
                tick        = 1'b1;
                phase_nxt_s = {PH_W{1'b0}};
            end else begin
                phase_nxt_s = phase_r + PH_W'(1);
            end
        end else begin
            phase_nxt_s = {PH_W{1'b0}};
        end
        half_nxt = (phase_nxt_s >= PH_HALF);
    end

    // Phase register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            phase_r <= {PH_W{1'b0}};
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

endmodule

// File: rtl/pmod_serial_tx.sv
// PMOD bit-serial transmitter: accepts a word by valid/ready, shifts it out LSB first
// with a frame strobe on bit 0 and a mid-bit clock, then idles for GAP_BITS bit periods.
module pmod_serial_tx
    import pmod_serial_pkg::*;
#(
    parameter int WORD_W       = WORD_W_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int GAP_BITS     = GAP_BITS_DEF
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [WORD_W-1:0] i_Data,
    input  logic              i_Valid,
    output logic              o_Ready,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_PMOD_Data,
    output logic              o_PMOD_Frame,
    output logic              o_PMOD_Clk
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);
    localparam bit HAS_GAP = (GAP_BITS > 0);

    state_t            state_r, state_nxt_s;
    logic [WORD_W-1:0] shift_r, shift_nxt_s;
    logic [BIT_W-1:0]  bitcnt_r, bitcnt_nxt_s;
    logic [GAP_W-1:0]  gapcnt_r, gapcnt_nxt_s;
    logic              done_nxt_s;
    logic              accept_s;
    logic              tick_s;
    logic              half_nxt_s;
    logic              ready_r, busy_r, done_r, data_r, frame_r, clk_r;

    assign accept_s = i_Valid && ready_r;

    pmod_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .clr      (accept_s),
        .en       (state_r != IDLE),
        .tick     (tick_s),
        .half_nxt (half_nxt_s)
    );

    // Next-state, shift register and bit/gap counter logic
    always_comb begin
        state_nxt_s  = state_r;
        shift_nxt_s  = shift_r;
        bitcnt_nxt_s = bitcnt_r;
        gapcnt_nxt_s = gapcnt_r;
        done_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s  = SHIFT;
                    shift_nxt_s  = i_Data;
                    bitcnt_nxt_s = {BIT_W{1'b0}};
                    gapcnt_nxt_s = {GAP_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (tick_s) begin
                    if (bitcnt_r == BIT_LAST) begin
                        state_nxt_s  = HAS_GAP ? GAP : IDLE;
                        done_nxt_s   = !HAS_GAP;
                        bitcnt_nxt_s = {BIT_W{1'b0}};
                        shift_nxt_s  = {WORD_W{1'b0}};
                    end else begin
                        bitcnt_nxt_s = bitcnt_r + BIT_W'(1);
                        shift_nxt_s  = shift_r >> 1;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            GAP: begin
                if (tick_s) begin
                    if (gapcnt_r == GAP_LAST) begin
                        state_nxt_s  = IDLE;
                        done_nxt_s   = 1'b1;
                        gapcnt_nxt_s = {GAP_W{1'b0}};
                    end else begin
                        gapcnt_nxt_s = gapcnt_r + GAP_W'(1);
                    end
                end else begin
                    state_nxt_s = GAP;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                shift_nxt_s  = {WORD_W{1'b0}};
                bitcnt_nxt_s = {BIT_W{1'b0}};
                gapcnt_nxt_s = {GAP_W{1'b0}};
            end
        endcase
    end

    // State registers; pins are registered from next-state values so they align with the state
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r  <= IDLE;
            shift_r  <= {WORD_W{1'b0}};
            bitcnt_r <= {BIT_W{1'b0}};
            gapcnt_r <= {GAP_W{1'b0}};
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            data_r   <= 1'b0;
            frame_r  <= 1'b0;
            clk_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            shift_r  <= shift_nxt_s;
            bitcnt_r <= bitcnt_nxt_s;
            gapcnt_r <= gapcnt_nxt_s;
            ready_r  <= (state_nxt_s == IDLE);
            busy_r   <= (state_nxt_s != IDLE);
            done_r   <= done_nxt_s;
            data_r   <= (state_nxt_s == SHIFT) && shift_nxt_s[0];
            frame_r  <= (state_nxt_s == SHIFT) && (bitcnt_nxt_s == {BIT_W{1'b0}});
            clk_r    <= (state_nxt_s == SHIFT) && half_nxt_s;
        end
    end

    assign o_Ready      = ready_r;
    assign o_Busy       = busy_r;
    assign o_Done       = done_r;
    assign o_PMOD_Data  = data_r;
    assign o_PMOD_Frame = frame_r;
    assign o_PMOD_Clk   = clk_r;

endmodule

// File: tb/tb_pmod_serial_tx.sv
// Scoreboard bench for pmod_serial_tx: lane 0 uses defaults, lane 1 uses CLKS_PER_BIT=4, GAP_BITS=0.
// Expected per-cycle pin levels and completion records come from a frame-level model.
module tb_pmod_serial_tx;

    localparam int KEYM = 1 << 20;

    typedef struct {
        int         lane;
        logic [8:0] word;
        int         done_cyc;
    } exp_t;

    logic       i_Clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] data_in  [2];
    logic       valid_in [2];
    logic       ready_o  [2];
    logic       busy_o   [2];
    logic       done_o   [2];
    logic       pd_o     [2];
    logic       pf_o     [2];
    logic       pc_o     [2];

    int         cpb  [2] = '{2, 4};
    int         gapb [2] = '{1, 0};
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    bit [3:0]   exp_pins [int];
    exp_t       q [$];
    logic [8:0] rx [2];
    logic       prev_clk [2];

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    pmod_serial_tx u_dut0 (
        .i_Clk        (i_Clk),
        .i_Rst_L      (rst_n),
        .i_Data       (data_in[0]),
        .i_Valid      (valid_in[0]),
        .o_Ready      (ready_o[0]),
        .o_Busy       (busy_o[0]),
        .o_Done       (done_o[0]),
        .o_PMOD_Data  (pd_o[0]),
        .o_PMOD_Frame (pf_o[0]),
        .o_PMOD_Clk   (pc_o[0])
    );

    pmod_serial_tx #(
        .CLKS_PER_BIT (4),
        .GAP_BITS     (0)
    ) u_dut1 (
        .i_Clk        (i_Clk),
        .i_Rst_L      (rst_n),
        .i_Data       (data_in[1]),
        .i_Valid      (valid_in[1]),
        .o_Ready      (ready_o[1]),
        .o_Busy       (busy_o[1]),
        .o_Done       (done_o[1]),
        .o_PMOD_Data  (pd_o[1]),
        .o_PMOD_Frame (pf_o[1]),
        .o_PMOD_Clk   (pc_o[1])
    );

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    // Frame model: word accepted in cycle c occupies cycles c+1 .. c+cpb*9, then gap, then done.
    task automatic add_frame(input int L, input logic [8:0] w, input int c);
        int nbits = cpb[L] * 9;
        int ngap  = cpb[L] * gapb[L];
        exp_t e;
        for (int k = 0; k < nbits; k++) begin
            exp_pins[L * KEYM + c + 1 + k] = {1'b1, (k < cpb[L]), ((k % cpb[L]) >= (cpb[L] / 2)), w[k / cpb[L]]};
        end
        for (int k = 0; k < ngap; k++) begin
            exp_pins[L * KEYM + c + 1 + nbits + k] = 4'b1000;
        end
        e.lane     = L;
        e.word     = w;
        e.done_cyc = c + 1 + nbits + ngap;
        q.push_back(e);
    endtask

    // Monitor: compares pins each cycle, receives bits on clock rise, retires words on done
    initial begin
        prev_clk[0] = 1'b0;
        prev_clk[1] = 1'b0;
        rx[0] = 9'd0;
        rx[1] = 9'd0;
        forever begin
            @(negedge i_Clk);
            if (rst_n) begin
                for (int L = 0; L < 2; L++) begin
                    automatic int       key = L * KEYM + cyc;
                    automatic bit [3:0] e   = exp_pins.exists(key) ? exp_pins[key] : 4'b0000;
                    automatic int       idx = -1;
                    chk($sformatf("pins%0d", L), int'({busy_o[L], pf_o[L], pc_o[L], pd_o[L]}), int'(e));
                    chk($sformatf("ready%0d", L), int'(ready_o[L]), int'(!e[3]));
                    if (pc_o[L] && !prev_clk[L]) begin
                        rx[L] = {pd_o[L], rx[L][8:1]};
                    end
                    prev_clk[L] = pc_o[L];
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i].lane == L) begin
                            idx = i;
                            break;
                        end
                    end
                    if (idx >= 0 && q[idx].done_cyc == cyc) begin
                        chk($sformatf("done_pulse%0d", L), int'(done_o[L]), 1);
                        chk($sformatf("rx_word%0d", L), int'(rx[L]), int'(q[idx].word));
                        q.delete(idx);
                    end else begin
                        chk($sformatf("done_quiet%0d", L), int'(done_o[L]), 0);
                    end
                    if (valid_in[L] && !e[3]) begin
                        add_frame(L, data_in[L], cyc);
                    end
                end
            end else begin
                prev_clk[0] = 1'b0;
                prev_clk[1] = 1'b0;
            end
        end
    end

    // Presents a word and holds i_Valid until it is accepted; leaves i_Valid high
    task automatic send(input int L, input logic [8:0] w);
        logic acc;
        data_in[L]  = w;
        valid_in[L] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            acc = ready_o[L];
            @(posedge i_Clk);
            #2;
            if (acc) return;
        end
        chk($sformatf("send_accept%0d", L), int'(ready_o[L]), 1);
    endtask

    task automatic idle(input int L, input int n);
        valid_in[L] = 1'b0;
        repeat (n) begin
            @(posedge i_Clk);
            #2;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            if (q.size() == 0) break;
            @(posedge i_Clk);
            #2;
        end
        chk("drain", q.size(), 0);
        idle(0, 2);
    endtask

    task automatic check_quiet(input string nm);
        for (int L = 0; L < 2; L++) begin
            chk($sformatf("%s_pins%0d", nm, L), int'({busy_o[L], pf_o[L], pc_o[L], pd_o[L]}), 0);
            chk($sformatf("%s_ready%0d", nm, L), int'(ready_o[L]), 1);
            chk($sformatf("%s_done%0d", nm, L), int'(done_o[L]), 0);
        end
    endtask

    initial begin
        data_in[0]  = 9'd0;
        data_in[1]  = 9'd0;
        valid_in[0] = 1'b0;
        valid_in[1] = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge i_Clk);
        #2;
        check_quiet("reset");
        rst_n = 1'b1;
        idle(0, 2);

        send(0, 9'h0A5);
        idle(0, 1);
        drain();

        send(0, 9'h1FF);
        idle(0, 1);
        drain();

        send(0, 9'h001);
        send(0, 9'h100);
        idle(0, 1);
        drain();

        send(0, 9'h155);
        send(0, 9'h0FF);
        idle(0, 1);
        drain();

        // Abort mid-frame during bit 4
        send(0, 9'h0A5);
        idle(0, 8);
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        for (int c = cyc - 2; c < cyc + 200; c++) begin
            if (exp_pins.exists(c)) exp_pins.delete(c);
            if (exp_pins.exists(KEYM + c)) exp_pins.delete(KEYM + c);
        end
        q.delete();
        repeat (2) @(posedge i_Clk);
        #2;
        rst_n = 1'b1;
        idle(0, 30);
        chk("abort_no_done", q.size(), 0);

        send(1, 9'd99);
        idle(1, 1);
        drain();

        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    send(0, 9'($urandom_range(0, 511)));
                    if ($urandom_range(0, 1) == 1) idle(0, $urandom_range(0, 25));
                end
                idle(0, 1);
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    send(1, 9'($urandom_range(0, 511)));
                    if ($urandom_range(0, 1) == 1) idle(1, $urandom_range(0, 40));
                end
                idle(1, 1);
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
